nand_netlist_sequencer: RTL and testbench
=========================================

# nand_netlist_sequencer

Bit-serial evaluator that executes a stored list of 2-input NAND operations, one per clock, against a small bit register file using a single shared NAND. It sequences the gate-level netlists our NAND-only flow produces, so a mapped design can be stepped and checked in a compact form instead of as a flat gate array. A host loads the program and the input bits, pulses `start`, waits for `done`, then reads the result bits.

## Interface
- `NBITS`, 16: register-file size in bits; IW = clog2(NBITS) is the index width.
- `PROG_DEPTH`, 32: instruction memory depth; PW = clog2(PROG_DEPTH) is the address width, LW = clog2(PROG_DEPTH+1) is the length width.

- `C`  in  1  clock; all state changes on its rising edge.
- `R`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin execution; sampled only in IDLE.
- `len`  in  LW  number of instructions to run; latched with `start`; values above PROG_DEPTH are clamped to PROG_DEPTH.
- `prog_we`  in  1  instruction memory write strobe.
- `prog_addr`  in  PW  instruction address.
- `prog_wdata`  in  3*IW  instruction word {dst, srcA, srcB}, with dst in the MSBs.
- `in_we`  in  1  register-file bit write strobe.
- `in_addr`  in  IW  register-file bit index for writes.
- `in_data`  in  1  bit value to write.
- `rd_addr`  in  IW  register-file read index.
- `rd_data`  out  1  combinational read of `regs[rd_addr]`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **State machine:** IDLE, RUN, DONE.
- **IDLE:**
  - `prog_we` writes `prog[prog_addr]`.
  - `in_we` writes `regs[in_addr]`.
  - If both write strobes and `start` are high in the same cycle, the writes land first and execution begins the next cycle.
  - `start` with clamped `len` = 0 goes to DONE.
  - `start` with `len` > 0 goes to RUN with `pc` = 0.
- **RUN:** each cycle:
  - Fetch `prog[pc]`.
  - Write `regs[dst] <= ~(regs[srcA] & regs[srcB])`.
  - If `pc` == `len` − 1, go to DONE; otherwise `pc` increments.
- **DONE:** `done` = 1 for exactly one cycle, then return to IDLE.
- **Operand reads** use register-file contents from before the current edge. Instruction k therefore sees every result of instructions 0..k−1.
- **Aliasing:** `srcA` = `srcB` gives NOT. `dst` equal to a source is legal and reads the old value.
- **Out-of-range index:** any index ≥ NBITS reads 0. A `dst` ≥ NBITS suppresses the write.
- **Ignored while busy:** `prog_we`, `in_we` and `start` are ignored in RUN and DONE. No state changes from them.
- **Reset `R`:**
  - State to IDLE, `pc` to 0, latched `len` to 0.
  - All `regs` cleared to 0.
  - `busy` = 0, `done` = 0.
  - Instruction memory is not cleared.
  - Reset takes priority over every other input in the same cycle, including mid-RUN. A run aborted by reset never produces `done`.

## Timing
- Let `start` be sampled in IDLE at edge t.
- **`len` = N > 0:**
  - `busy` rises after edge t.
  - Instruction k writes at edge t+1+k.
  - DONE is occupied for the cycle after edge t+N. `done` and `busy` fall after edge t+N+1.
  - Total latency from `start` to `done`: N+1 cycles.
- **`len` = 0:** `done` is high in the cycle after edge t; latency is 1 cycle.
- **Result readability:** `rd_data` reflects the final result in the `done` cycle and after.
- **Restart:** a new `start` is accepted at the first edge where the state is IDLE again, i.e. edge t+N+2 at the earliest.
- **Throughput:** one NAND per cycle, with no bubbles between dependent instructions.

## Test plan
- **NOT:** `regs[0]`=1; prog[0]={dst 1, srcA 0, srcB 0}; `len`=1; `start`.
  - Required: `done` 2 cycles after `start`; `regs[1]`=0.
  - Repeat with `regs[0]`=0; required: `regs[1]`=1.
- **XOR from 4 NANDs:** r2=nand(r0,r1), r3=nand(r0,r2), r4=nand(r1,r2), r5=nand(r3,r4); `len`=4.
  - Run inputs (r0,r1) = 00, 01, 10, 11.
  - Required `regs[5]` = 0, 1, 1, 0; `done` 5 cycles after each `start`.
- **`len`=0:** `start`.
  - Required: `done` pulses in the next cycle, `busy` high for exactly 1 cycle, `regs` unchanged.
- **Busy rejection:** during the XOR run, pulse `start`, and `in_we` to `regs[0]`, and `prog_we` to prog[0].
  - Required: identical result and `done` timing; `regs[0]` and prog[0] unchanged afterwards.
- **Reset mid-run:** assert `R` one cycle after the XOR run's `start` (i.e. in RUN).
  - Required: next cycle `busy`=0 and `done`=0, all `regs`=0, and no `done` pulse ever appears.
  - Then reload r0=1, r1=0 and rerun: `regs[5`]=1, confirming the program survived reset.
- **`len` clamp and aliasing:** `len`=PROG_DEPTH+1 with the program filled with {dst 0, srcA 0, srcB 0}, `regs[0]`=1.
  - Required: exactly PROG_DEPTH=32 toggles, `regs[0]`=1 at `done`, and `done` 33 cycles after `start`.

Source files
------------

// File: rtl/nand_netlist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nand_netlist_sequencer
// Purpose  : Bit-serial evaluator that steps a stored list of 2-input NAND
//            instructions {dst, srcA, srcB} through one shared NAND, one
//            instruction per clock, against a small bit register file.
// Revision : 1.0 - initial release
// ============================================================================
module nand_netlist_sequencer #(
    parameter  int NBITS      = 16,
    parameter  int PROG_DEPTH = 32,
    localparam int c_IW       = $clog2(NBITS),
    localparam int c_PW       = $clog2(PROG_DEPTH),
    localparam int c_LW       = $clog2(PROG_DEPTH + 1)
) (
    input  logic              C,
    input  logic              R,
    input  logic              start,
    input  logic [c_LW-1:0]   len,
    input  logic              prog_we,
    input  logic [c_PW-1:0]   prog_addr,
    input  logic [3*c_IW-1:0] prog_wdata,
    input  logic              in_we,
    input  logic [c_IW-1:0]   in_addr,
    input  logic              in_data,
    input  logic [c_IW-1:0]   rd_addr,
    output logic              rd_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and sequencing state
    // ------------------------------------------------------------------------
    logic [3*c_IW-1:0] r_prog [PROG_DEPTH];   // instruction memory, never reset
    logic [NBITS-1:0]  r_regs;                // bit register file
    state_t            r_state;
    logic [c_PW-1:0]   r_pc;
    logic [c_LW-1:0]   r_len;

    state_t            w_state_next;
    logic [c_PW-1:0]   w_pc_next;
    logic [c_LW-1:0]   w_len_next;

    logic [c_LW-1:0]   w_len_clamped;
    logic              w_last;
    logic [3*c_IW-1:0] w_instr;
    logic [c_IW-1:0]   w_dst;
    logic [c_IW-1:0]   w_src_a;
    logic [c_IW-1:0]   w_src_b;
    logic              w_op_a;
    logic              w_op_b;
    logic              w_nand;
    logic              w_dst_ok;
    logic              w_in_ok;
    logic              w_prog_ok;

    // Register indices beyond NBITS read as 0 and are never written; the
    // comparison is done at 32 bits so it also works for non-power-of-two sizes.
    function automatic logic f_idx_ok(input logic [c_IW-1:0] idx);
        return 32'(idx) < 32'(NBITS);
    endfunction

    // Requests longer than the memory run the whole memory exactly once.
    assign w_len_clamped = (32'(len) > 32'(PROG_DEPTH)) ? c_LW'(PROG_DEPTH) : len;

    // Last instruction of the run when pc reaches len-1 (len is never 0 in RUN).
    assign w_last = (c_LW'(r_pc) == (r_len - c_LW'(1)));

    // Instruction decode: dst in the MSBs, then srcA, then srcB.
    assign w_instr = r_prog[r_pc];
    assign w_dst   = w_instr[3*c_IW-1:2*c_IW];
    assign w_src_a = w_instr[2*c_IW-1:c_IW];
    assign w_src_b = w_instr[c_IW-1:0];

    // Operands come from the register file as it stood before this edge, so a
    // dst that aliases a source still sees the old value.
    assign w_op_a   = f_idx_ok(w_src_a) ? r_regs[w_src_a] : 1'b0;
    assign w_op_b   = f_idx_ok(w_src_b) ? r_regs[w_src_b] : 1'b0;
    assign w_nand   = ~(w_op_a & w_op_b);
    assign w_dst_ok = f_idx_ok(w_dst);

    assign w_in_ok   = f_idx_ok(in_addr);
    assign w_prog_ok = 32'(prog_addr) < 32'(PROG_DEPTH);

    // Host read port is purely combinational.
    assign rd_data = f_idx_ok(rd_addr) ? r_regs[rd_addr] : 1'b0;

    // ------------------------------------------------------------------------
    // State register: FSM state, program counter and latched length.
    // ------------------------------------------------------------------------
    always_ff @(posedge C) begin
        if (R) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_len   <= w_len_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_len_next   = r_len;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_next   = w_len_clamped;
                    w_pc_next    = '0;
                    w_state_next = (w_len_clamped == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_pc_next = r_pc + c_PW'(1);
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Register file: host writes in IDLE, NAND results during RUN.
    always_ff @(posedge C) begin
        if (R) begin
            r_regs <= '0;
        end else if ((r_state == S_IDLE) && in_we && w_in_ok) begin
            r_regs[in_addr] <= in_data;
        end else if ((r_state == S_RUN) && w_dst_ok) begin
            r_regs[w_dst] <= w_nand;
        end
    end

    // Instruction memory load; only in IDLE, and reset blocks the write.
    always_ff @(posedge C) begin
        if (!R && (r_state == S_IDLE) && prog_we && w_prog_ok) begin
            r_prog[prog_addr] <= prog_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nand_netlist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nand_netlist_sequencer
// Purpose  : Directed self-checking bench for nand_netlist_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nand_netlist_sequencer;

    localparam int c_IW = 4;
    localparam int c_PW = 5;
    localparam int c_LW = 6;

    logic              C = 1'b0;
    logic              R = 1'b1;
    logic              start = 1'b0;
    logic [c_LW-1:0]   len = '0;
    logic              prog_we = 1'b0;
    logic [c_PW-1:0]   prog_addr = '0;
    logic [3*c_IW-1:0] prog_wdata = '0;
    logic              in_we = 1'b0;
    logic [c_IW-1:0]   in_addr = '0;
    logic              in_data = 1'b0;
    logic [c_IW-1:0]   rd_addr = '0;
    logic              rd_data;
    logic              busy;
    logic              done;

    int n_total = 0;
    int n_pass  = 0;

    nand_netlist_sequencer #(.NBITS(16), .PROG_DEPTH(32)) dut (
        .C          (C),
        .R          (R),
        .start      (start),
        .len        (len),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .in_we      (in_we),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 C = ~C;

    // Global time bound so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [3*c_IW-1:0] ins(input int d, input int a, input int b);
        return {c_IW'(d), c_IW'(a), c_IW'(b)};
    endfunction

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic wr_reg(input int a, input logic d);
        in_we = 1'b1; in_addr = c_IW'(a); in_data = d;
        tick();
        in_we = 1'b0;
    endtask

    task automatic wr_prog(input int a, input logic [3*c_IW-1:0] w);
        prog_we = 1'b1; prog_addr = c_PW'(a); prog_wdata = w;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic exp);
        rd_addr = c_IW'(a);
        #1;
        chk(tag, int'(rd_data), int'(exp));
    endtask

    // Start a run, wait (bounded) for done, check latency, busy length and
    // the result bit in the done cycle, then check the return to idle.
    // With inject set, start/in_we/prog_we are pulsed while the run is busy.
    task automatic run(input string tag, input int n, input int exp_cycles,
                       input int ra, input logic exp_bit, input bit inject);
        int  cycles;
        int  busy_cnt;
        bit  seen;
        cycles = 0; busy_cnt = 0; seen = 1'b0;
        rd_addr = c_IW'(ra);
        len     = c_LW'(n);
        start   = 1'b1;
        while (!seen && cycles < 100) begin
            tick();
            start = 1'b0; in_we = 1'b0; prog_we = 1'b0;
            cycles++;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                chk({tag, " rd@done"}, int'(rd_data), int'(exp_bit));
            end
            if (inject && cycles == 2) begin
                start      = 1'b1; len = 6'd1;
                in_we      = 1'b1; in_addr = 4'd0; in_data = 1'b0;
                prog_we    = 1'b1; prog_addr = 5'd0; prog_wdata = ins(2, 0, 0);
            end
        end
        chk({tag, " latency"}, cycles, exp_cycles);
        chk({tag, " busy_cycles"}, busy_cnt, exp_cycles);
        tick();
        chk({tag, " done_after"}, int'(done), 0);
        chk({tag, " busy_after"}, int'(busy), 0);
    endtask

    initial begin
        bit saw_done;

        // Reset: program writes during reset must be blocked too.
        prog_we = 1'b1; prog_addr = 5'd0; prog_wdata = ins(1, 0, 0);
        tick();
        tick();
        prog_we = 1'b0;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        rd_chk("reset r0", 0, 1'b0);
        R = 1'b0;
        tick();

        // NOT: r1 = nand(r0, r0).
        wr_prog(0, ins(1, 0, 0));
        wr_reg(0, 1'b1);
        run("not r0=1", 1, 2, 1, 1'b0, 1'b0);
        rd_chk("not r0 kept", 0, 1'b1);
        // Write r0=0 in the same cycle as start: the write lands first.
        in_we = 1'b1; in_addr = 4'd0; in_data = 1'b0;
        run("not r0=0", 1, 2, 1, 1'b1, 1'b0);

        // XOR from four NANDs, all input combinations.
        wr_prog(0, ins(2, 0, 1));
        wr_prog(1, ins(3, 0, 2));
        wr_prog(2, ins(4, 1, 2));
        wr_prog(3, ins(5, 3, 4));
        wr_reg(0, 1'b0); wr_reg(1, 1'b0);
        run("xor 00", 4, 5, 5, 1'b0, 1'b0);
        wr_reg(0, 1'b0); wr_reg(1, 1'b1);
        run("xor 01", 4, 5, 5, 1'b1, 1'b0);
        wr_reg(0, 1'b1); wr_reg(1, 1'b0);
        run("xor 10", 4, 5, 5, 1'b1, 1'b0);
        wr_reg(0, 1'b1); wr_reg(1, 1'b1);
        run("xor 11", 4, 5, 5, 1'b0, 1'b0);
        rd_chk("xor 11 r2", 2, 1'b0);

        // len = 0: straight to DONE, registers untouched.
        run("len0", 0, 1, 5, 1'b0, 1'b0);
        rd_chk("len0 r0", 0, 1'b1);
        rd_chk("len0 r1", 1, 1'b1);
        rd_chk("len0 r2", 2, 1'b0);

        // Busy rejection: strobes during RUN must have no effect.
        wr_reg(0, 1'b1); wr_reg(1, 1'b0);
        run("busy rej", 4, 5, 5, 1'b1, 1'b1);
        rd_chk("busy rej r0", 0, 1'b1);
        rd_chk("busy rej r2", 2, 1'b1);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy || done) saw_done = 1'b1;
        end
        chk("busy rej no restart", int'(saw_done), 0);

        // Reset in the middle of a run.
        wr_reg(0, 1'b1); wr_reg(1, 1'b0);
        len = 6'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("midrst running", int'(busy), 1);
        R = 1'b1;
        tick();
        R = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("midrst no done", int'(saw_done), 0);
        for (int i = 0; i < 16; i++) begin
            rd_chk($sformatf("midrst r%0d", i), i, 1'b0);
        end
        // Program survives reset (and the rejected prog write): 1^0 = 1.
        wr_reg(0, 1'b1); wr_reg(1, 1'b0);
        run("after rst xor", 4, 5, 5, 1'b1, 1'b0);
        rd_chk("after rst r2", 2, 1'b1);

        // Length clamp with full aliasing: 32 toggles of r0.
        for (int i = 0; i < 32; i++) begin
            wr_prog(i, ins(0, 0, 0));
        end
        wr_reg(0, 1'b1);
        run("clamp", 33, 33, 0, 1'b1, 1'b0);
        rd_chk("clamp r5 kept", 5, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
